// File: rtl/uart_byte_rx_pkg.sv
// rtl/uart_byte_rx_pkg.sv - shared types and constants for the UART byte receiver
// Purpose: receiver state encoding, default bit timing, ASCII codes used by the move path.
// Ports: none (package).
package uart_byte_rx_pkg;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_W    = 8'h57;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_CLEANUP    = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - serial line in, received byte and status out
// Purpose: bundles the UART line and the byte/strobe outputs of the receiver.
// Ports: rx_serial (line, idles high), rx_byte, rx_finish (good-byte strobe),
//        rx_busy (frame in progress), frame_error (bad stop bit strobe).
// master: the receiver; slave: the line driver / downstream consumer.
interface uart_byte_rx_if;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_finish;
    logic       rx_busy;
    logic       frame_error;

    modport master (
        input  rx_serial,
        output rx_byte,
        output rx_finish,
        output rx_busy,
        output frame_error
    );

    modport slave (
        output rx_serial,
        input  rx_byte,
        input  rx_finish,
        input  rx_busy,
        input  frame_error
    );
endinterface

// File: rtl/uart_byte_rx_line_sync.sv
// rtl/uart_byte_rx_line_sync.sv - metastability flop chain for an idle-high async line
// Purpose: STAGES-deep synchronizer; flops preset to 1 so reset looks like an idle line.
// Ports: clock, reset (async, active high), d (async input), q (synchronized output).
module line_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART receiver producing one strobe per good byte
// Purpose: recovers start/8 data (LSB first)/stop frames; good frames update rx_byte
//          with a one-cycle rx_finish, bad stop bits give a one-cycle frame_error.
// Ports: clock, reset (async, active high), bus (uart_byte_rx_if.master).
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clock,
    input  logic             reset,
    uart_byte_rx_if.master   bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // The IDLE->START transition cycle already counts toward the half bit, so
    // START samples one count early; this centres the sample in the start bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic rxs;

    rx_state_e        state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       byte_q,    byte_d;
    logic             finish_q,  finish_d;
    logic             ferr_q,    ferr_d;

    line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.rx_serial),
        .q     (rxs)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            finish_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            finish_q  <= finish_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        finish_d  = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    // Line back high at mid start bit: treat as a glitch
                    state_d   = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rxs;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rxs) begin
                        byte_d   = shift_q;
                        finish_d = 1'b1;
                        state_d  = ST_CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK_WAIT;
                    end
                end
            end
            ST_CLEANUP: begin
                clk_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            ST_BREAK_WAIT: begin
                // A held-low line must not be mistaken for a stream of start bits
                clk_cnt_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign bus.rx_byte     = byte_q;
    assign bus.rx_finish   = finish_q;
    assign bus.frame_error = ferr_q;
    assign bus.rx_busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - directed self-checking bench for uart_byte_rx
module tb_uart_byte_rx;
    import uart_byte_rx_pkg::*;

    localparam int BIT_T = 80;   // 8 clocks of 10 time units

    logic clock;
    logic reset;
    int   tests_run;
    int   fails;
    int   cyc;

    int   fin_cnt;
    int   ferr_cnt;
    int   busy_cnt;
    int   overlap_cnt;
    logic [7:0] byte_q_tb[$];
    int         cyc_q_tb[$];

    uart_byte_rx_if bus ();

    uart_byte_rx #(
        .CLKS_PER_BIT (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.rx_finish === 1'b1) begin
            fin_cnt = fin_cnt + 1;
            byte_q_tb.push_back(bus.rx_byte);
            cyc_q_tb.push_back(cyc);
        end
        if (bus.frame_error === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (bus.rx_busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (bus.rx_finish === 1'b1 && bus.frame_error === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
        bus.rx_serial = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            bus.rx_serial = b[i];
            #(bit_t);
        end
        bus.rx_serial = stop;
        #(bit_t);
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (bus.rx_finish !== 1'b0) begin fails++; $display("FAIL reset_finish got %b exp 0", bus.rx_finish); end
        tests_run++;
        if (bus.rx_byte !== 8'h00) begin fails++; $display("FAIL reset_byte got %h exp 00", bus.rx_byte); end
        tests_run++;
        if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.rx_busy); end
        tests_run++;
        if (bus.frame_error !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b exp 0", bus.frame_error); end
        idle(3);
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_single();
        int base, f0, e0;
        base = byte_q_tb.size();
        f0   = ferr_cnt;
        @(negedge clock);
        e0 = cyc;
        send_frame(8'h41, 1'b1, BIT_T);
        idle(10);
        tests_run++;
        if (byte_q_tb.size() - base !== 1) begin
            fails++; $display("FAIL single_count got %0d exp 1", byte_q_tb.size() - base);
        end else begin
            tests_run++;
            if (byte_q_tb[base] !== 8'h41) begin fails++; $display("FAIL single_byte got %h exp 41", byte_q_tb[base]); end
            tests_run++;
            if (cyc_q_tb[base] - e0 !== 78) begin fails++; $display("FAIL single_latency got %0d exp 78", cyc_q_tb[base] - e0); end
        end
        tests_run++;
        if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL single_ferr got %0d exp 0", ferr_cnt - f0); end
        tests_run++;
        if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL single_busy_after got %b exp 0", bus.rx_busy); end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [7:0] exp_b[3];
        exp_b[0] = ASCII_DASH;
        exp_b[1] = ASCII_W;
        exp_b[2] = ASCII_LF;
        base = byte_q_tb.size();
        @(negedge clock);
        for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1, BIT_T);
        idle(10);
        tests_run++;
        if (byte_q_tb.size() - base !== 3) begin
            fails++; $display("FAIL b2b_count got %0d exp 3", byte_q_tb.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (byte_q_tb[base+k] !== exp_b[k]) begin
                    fails++; $display("FAIL b2b_byte%0d got %h exp %h", k, byte_q_tb[base+k], exp_b[k]);
                end
            end
            for (int k = 1; k < 3; k++) begin
                tests_run++;
                if (cyc_q_tb[base+k] - cyc_q_tb[base+k-1] !== 80) begin
                    fails++; $display("FAIL b2b_spacing%0d got %0d exp 80", k, cyc_q_tb[base+k] - cyc_q_tb[base+k-1]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int f0, e0, b0, base;
        f0 = fin_cnt;
        e0 = ferr_cnt;
        b0 = busy_cnt;
        @(negedge clock);
        bus.rx_serial = 1'b0;
        idle(2);
        bus.rx_serial = 1'b1;
        idle(20);
        tests_run++;
        if (fin_cnt - f0 !== 0) begin fails++; $display("FAIL glitch_finish got %0d exp 0", fin_cnt - f0); end
        tests_run++;
        if (ferr_cnt - e0 !== 0) begin fails++; $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt - e0); end
        tests_run++;
        if (busy_cnt - b0 <= 0) begin fails++; $display("FAIL glitch_busy_pulse got %0d cycles exp >0", busy_cnt - b0); end
        tests_run++;
        if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_after got %b exp 0", bus.rx_busy); end
        base = byte_q_tb.size();
        send_frame(8'hA5, 1'b1, BIT_T);
        idle(10);
        tests_run++;
        if (byte_q_tb.size() - base !== 1 || byte_q_tb[byte_q_tb.size()-1] !== 8'hA5) begin
            fails++; $display("FAIL glitch_next_frame got n=%0d byte=%h exp n=1 byte=a5", byte_q_tb.size() - base, bus.rx_byte);
        end
    endtask

    task automatic test_frame_error();
        int f0, e0, base;
        @(negedge clock);
        send_frame(8'h33, 1'b1, BIT_T);
        idle(5);
        f0 = fin_cnt;
        e0 = ferr_cnt;
        send_frame(8'h55, 1'b0, BIT_T);
        #(30 * BIT_T);
        tests_run++;
        if (ferr_cnt - e0 !== 1) begin fails++; $display("FAIL ferr_pulses got %0d exp 1", ferr_cnt - e0); end
        tests_run++;
        if (fin_cnt - f0 !== 0) begin fails++; $display("FAIL ferr_finish got %0d exp 0", fin_cnt - f0); end
        tests_run++;
        if (bus.rx_byte !== 8'h33) begin fails++; $display("FAIL ferr_byte_held got %h exp 33", bus.rx_byte); end
        bus.rx_serial = 1'b1;
        idle(20);
        base = byte_q_tb.size();
        send_frame(8'h10, 1'b1, BIT_T);
        idle(10);
        tests_run++;
        if (byte_q_tb.size() - base !== 1 || bus.rx_byte !== 8'h10) begin
            fails++; $display("FAIL ferr_recover got n=%0d byte=%h exp n=1 byte=10", byte_q_tb.size() - base, bus.rx_byte);
        end
        tests_run++;
        if (ferr_cnt - e0 !== 1) begin fails++; $display("FAIL ferr_after_break got %0d exp 1", ferr_cnt - e0); end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [7:0] ff_b;
        ff_b = 8'hFF;
        @(negedge clock);
        bus.rx_serial = 1'b0;
        idle(8);
        for (int i = 0; i < 4; i++) begin
            bus.rx_serial = ff_b[i];
            idle(8);
        end
        bus.rx_serial = ff_b[4];
        idle(4);
        tests_run++;
        if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL midreset_busy_before got %b exp 1", bus.rx_busy); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.rx_byte !== 8'h00 || bus.rx_busy !== 1'b0 || bus.rx_finish !== 1'b0 || bus.frame_error !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs got byte=%h busy=%b fin=%b ferr=%b exp all 0",
                              bus.rx_byte, bus.rx_busy, bus.rx_finish, bus.frame_error);
        end
        bus.rx_serial = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(10);
        base = byte_q_tb.size();
        send_frame(8'h0A, 1'b1, BIT_T);
        idle(10);
        tests_run++;
        if (byte_q_tb.size() - base !== 1 || bus.rx_byte !== 8'h0A) begin
            fails++; $display("FAIL midreset_recover got n=%0d byte=%h exp n=1 byte=0a", byte_q_tb.size() - base, bus.rx_byte);
        end
    endtask

    task automatic test_tolerance();
        int base, e0;
        int rates[2];
        rates[0] = 77;
        rates[1] = 83;
        e0 = ferr_cnt;
        for (int r = 0; r < 2; r++) begin
            base = byte_q_tb.size();
            @(negedge clock);
            #2;
            send_frame(8'h96, 1'b1, rates[r]);
            idle(20);
            tests_run++;
            if (byte_q_tb.size() - base !== 1 || bus.rx_byte !== 8'h96) begin
                fails++; $display("FAIL tolerance_%0d got n=%0d byte=%h exp n=1 byte=96", rates[r], byte_q_tb.size() - base, bus.rx_byte);
            end
        end
        tests_run++;
        if (ferr_cnt - e0 !== 0) begin fails++; $display("FAIL tolerance_ferr got %0d exp 0", ferr_cnt - e0); end
    endtask

    initial begin
        clock         = 1'b0;
        reset         = 1'b1;
        bus.rx_serial = 1'b1;
        cyc           = 0;
        tests_run     = 0;
        fails         = 0;
        fin_cnt       = 0;
        ferr_cnt      = 0;
        busy_cnt      = 0;
        overlap_cnt   = 0;

        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid();
        test_tolerance();

        tests_run++;
        if (overlap_cnt !== 0) begin fails++; $display("FAIL strobe_overlap got %0d exp 0", overlap_cnt); end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
Serial-to-byte receiver that sits directly upstream of the move-assembly receiver. It samples the asynchronous UART line and recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit). For each good frame it presents a byte on rx_byte with a single-cycle rx_finish strobe. Framing faults are flagged and never produce a strobe, so the downstream stage only ever sees valid characters.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
SYNC_STAGES, 2, metastability flops on rx_serial; legal range 2..3.

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
rx_serial  input  1  asynchronous UART line; idles high.
rx_finish  output  1  one-cycle strobe; rx_byte is valid in the same cycle.
rx_byte  output  8  last good received byte; held until the next good frame.
rx_busy  output  1  high from start-bit detection until return to IDLE.
frame_error  output  1  one-cycle strobe when the stop bit samples 0.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; rx_finish=0, rx_byte=8'h00, rx_busy=0, frame_error=0; bit counter and clock counter = 0; synchronizer flops preset to 1 (idle line).
- All decisions use the synchronized line rxs, which lags rx_serial by SYNC_STAGES cycles.
- Clock counter width is clog2(CLKS_PER_BIT). Bit index is 3 bits and does not wrap past 7.
- State machine:
  - IDLE: on rxs==0, go to START, clear the clock counter, set rx_busy=1.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division), then sample rxs.
    - rxs==0: valid start; clear counter and bit index; go to DATA.
    - rxs==1: glitch; go to IDLE, rx_busy=0, no strobe.
  - DATA: count to CLKS_PER_BIT-1, then sample rxs into shift[bit_index], LSB first.
    - After bit 7, go to STOP; otherwise increment the bit index.
  - STOP: count to CLKS_PER_BIT-1, then sample rxs.
    - rxs==1: rx_byte<=shift; rx_finish=1 for exactly one cycle (the cycle after the sample); go to CLEANUP.
    - rxs==0: frame_error=1 for one cycle; rx_byte unchanged; go to BREAK_WAIT.
  - CLEANUP: one cycle; go to IDLE, rx_busy=0.
  - BREAK_WAIT: hold until rxs==1, then go to IDLE, rx_busy=0. A held-low line (break) therefore yields exactly one frame_error and no spurious frames.
- Sampling and latency:
  - Each bit is sampled mid-bit.
  - rx_finish rises SYNC_STAGES + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles after the rx_serial falling edge.
- Back-to-back frames: a start edge arriving during CLEANUP is caught on the first IDLE cycle; the loss is at most 1 cycle and is absorbed by the half-bit centring.
- Tolerance: correct reception with bit period within ±4% of nominal.
- Output rules:
  - rx_finish and frame_error are never high in the same cycle.
  - Minimum spacing between strobes is 10*CLKS_PER_BIT - 1 cycles.
  - The downstream stage samples rx_byte on the strobe; it need not be faster.
- Reset mid-frame returns to IDLE immediately. The partially shifted byte is discarded, and rx_byte reads 8'h00.

Decomposition:
- Shared package: state encodings (IDLE, START, DATA, STOP, CLEANUP, BREAK_WAIT as a 3-bit type), default CLKS_PER_BIT, and the ASCII constants the move path uses ('\n'=8'h0A, '-'=8'h2D, 'W'=8'h57).
- One sub-module: line_sync, a parameterised SYNC_STAGES flop chain with async preset to 1, reusable by the transmit-side CTS input.

Test Plan:
All cases use CLKS_PER_BIT=8 and SYNC_STAGES=2.
- Single frame 8'h41 -> exactly one rx_finish; rx_byte=8'h41 on that cycle; frame_error never set; rx_busy low afterwards; latency 2+3+72+1=78 cycles from the falling edge.
- Back-to-back "-W\n" (8'h2D, 8'h57, 8'h0A, stop bits of exactly 1 bit) -> three rx_finish strobes carrying 2D, 57, 0A in order, spaced 80 cycles apart.
- 2-cycle low glitch on an idle line -> no rx_finish, no frame_error; rx_busy pulses then returns to 0; the following frame 8'hA5 is received correctly.
- Frame 8'h55 with stop bit 0, after an earlier good 8'h33 -> one frame_error pulse, no rx_finish, rx_byte stays 8'h33; then hold the line low for 30 bit times -> no further strobes; line high then frame 8'h10 -> received.
- Assert reset during data bit 4 of 8'hFF -> outputs read zero immediately; after release, frame 8'h0A -> rx_finish with rx_byte=8'h0A.
- Frames 8'h96 sent at 7.7 and 8.3 cycles/bit (fractional timing in the bench) -> both received as 8'h96 with no frame_error.
